// File: rtl/move_pkg.sv
// rtl/move_pkg.sv - shared types, address width and collision address helper for player_move_ctrl
package move_pkg;

    localparam int ADDR_W = 19;

    typedef enum logic [1:0] {
        DOWN  = 2'd0,
        UP    = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } facing_t;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        PRB0,
        PRB1,
        PRB2,
        DRAIN,
        DECIDE
    } state_t;

    function automatic logic [ADDR_W-1:0] coll_addr(
        input logic [10:0] row,
        input logic [10:0] col,
        input logic [10:0] stride
    );
        return ADDR_W'(row) * ADDR_W'(stride) + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/probe_gen.sv
// rtl/probe_gen.sv - leading-edge probe point to collision RAM address for a target footprint
import move_pkg::*;

module probe_gen #(
    parameter int MAP_W = 320,
    parameter int SPR_W = 16,
    parameter int SPR_H = 16
) (
    input  facing_t           dir,
    input  logic [10:0]       tgt_x,
    input  logic [10:0]       tgt_y,
    input  logic [1:0]        idx,
    output logic [ADDR_W-1:0] addr
);

    logic [10:0] col_l, col_r, col_m;
    logic [10:0] row_t, row_b, row_m;
    logic [10:0] row, col;

    assign col_l = tgt_x;
    assign col_r = tgt_x + 11'(SPR_W - 1);
    assign col_m = tgt_x + 11'(SPR_W / 2);
    assign row_t = tgt_y;
    assign row_b = tgt_y + 11'(SPR_H - 1);
    assign row_m = tgt_y + 11'(SPR_H / 2);

    // idx 0/1 are the two corners of the leading edge, idx 2 its midpoint
    always_comb begin
        row = row_t;
        col = col_l;
        if (dir == UP || dir == DOWN) begin
            row = (dir == UP) ? row_t : row_b;
            case (idx)
                2'd0:    col = col_l;
                2'd1:    col = col_r;
                default: col = col_m;
            endcase
        end else begin
            col = (dir == LEFT) ? col_l : col_r;
            case (idx)
                2'd0:    row = row_t;
                2'd1:    row = row_b;
                default: row = row_m;
            endcase
        end
    end

    assign addr = coll_addr(row, col, 11'(MAP_W));

endmodule

// File: rtl/player_move_ctrl.sv
// rtl/player_move_ctrl.sv - per-frame player move/collision FSM; COLL_MIDPOINT_EN adds a midpoint probe
import move_pkg::*;

module player_move_ctrl #(
    parameter int MAP_W   = 320,
    parameter int MAP_H   = 240,
    parameter int SPR_W   = 16,
    parameter int SPR_H   = 16,
    parameter int STEP    = 2,
    parameter int START_X = 152,
    parameter int START_Y = 112
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_tick,
    input  logic [3:0]        dir_keys,
    output logic [ADDR_W-1:0] coll_read_address,
    input  logic [3:0]        coll_data_In,
    output logic [8:0]        pos_x,
    output logic [7:0]        pos_y,
    output facing_t           facing,
    output logic              busy,
    output logic              blocked
);

    localparam logic [10:0] X_MAX = 11'(MAP_W - SPR_W);
    localparam logic [10:0] Y_MAX = 11'(MAP_H - SPR_H);

    state_t            state_q, state_d;
    facing_t           dir_q, dir_d;
    facing_t           facing_q, facing_d;
    logic [10:0]       tx_q, tx_d, ty_q, ty_d;
    logic [8:0]        pos_x_q, pos_x_d;
    logic [7:0]        pos_y_q, pos_y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              acc_q, acc_d;
    logic              blocked_q, blocked_d;

    logic [10:0]       tgt_x, tgt_y;
    logic              oob;
    logic [1:0]        prb_idx;
    logic [ADDR_W-1:0] probe_addr;
    facing_t           key_dir;

    // Target is two's complement in 11 bits so a step off the left/top edge shows as bit 10 set
    always_comb begin
        tgt_x = {2'b00, pos_x_q};
        tgt_y = {3'b000, pos_y_q};
        case (dir_q)
            UP:      tgt_y = {3'b000, pos_y_q} - 11'(STEP);
            DOWN:    tgt_y = {3'b000, pos_y_q} + 11'(STEP);
            LEFT:    tgt_x = {2'b00, pos_x_q} - 11'(STEP);
            default: tgt_x = {2'b00, pos_x_q} + 11'(STEP);
        endcase
        oob = tgt_x[10] || tgt_y[10] || (tgt_x > X_MAX) || (tgt_y > Y_MAX);
    end

    always_comb begin
        key_dir = RIGHT;
        if (dir_keys[3])      key_dir = UP;
        else if (dir_keys[2]) key_dir = DOWN;
        else if (dir_keys[1]) key_dir = LEFT;
    end

    // The address register is loaded one state early so it is valid throughout PRBk
    always_comb begin
        prb_idx = 2'd0;
        if (state_q == PRB0)      prb_idx = 2'd1;
        else if (state_q == PRB1) prb_idx = 2'd2;
    end

    probe_gen #(
        .MAP_W (MAP_W),
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_probe_gen (
        .dir   (dir_q),
        .tgt_x ((state_q == CALC) ? tgt_x : tx_q),
        .tgt_y ((state_q == CALC) ? tgt_y : ty_q),
        .idx   (prb_idx),
        .addr  (probe_addr)
    );

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        facing_d  = facing_q;
        tx_d      = tx_q;
        ty_d      = ty_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        addr_d    = addr_q;
        acc_d     = acc_q;
        blocked_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_tick && dir_keys != 4'd0) begin
                    dir_d   = key_dir;
                    state_d = CALC;
                end
            end
            CALC: begin
                tx_d     = tgt_x;
                ty_d     = tgt_y;
                facing_d = dir_q;
                acc_d    = oob;
                if (oob) begin
                    state_d = DECIDE;
                end else begin
                    addr_d  = probe_addr;
                    state_d = PRB0;
                end
            end
            PRB0: begin
                addr_d  = probe_addr;
                state_d = PRB1;
            end
            PRB1: begin
                acc_d = acc_q | (coll_data_In != 4'd0);
`ifdef COLL_MIDPOINT_EN
                addr_d  = probe_addr;
                state_d = PRB2;
`else
                state_d = DRAIN;
`endif
            end
            PRB2: begin
                acc_d   = acc_q | (coll_data_In != 4'd0);
                state_d = DRAIN;
            end
            DRAIN: begin
                acc_d   = acc_q | (coll_data_In != 4'd0);
                state_d = DECIDE;
            end
            DECIDE: begin
                if (acc_q) begin
                    blocked_d = 1'b1;
                end else begin
                    pos_x_d = tx_q[8:0];
                    pos_y_d = ty_q[7:0];
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            dir_q     <= DOWN;
            facing_q  <= DOWN;
            tx_q      <= '0;
            ty_q      <= '0;
            pos_x_q   <= 9'(START_X);
            pos_y_q   <= 8'(START_Y);
            addr_q    <= '0;
            acc_q     <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            facing_q  <= facing_d;
            tx_q      <= tx_d;
            ty_q      <= ty_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            addr_q    <= addr_d;
            acc_q     <= acc_d;
            blocked_q <= blocked_d;
        end
    end

    assign coll_read_address = addr_q;
    assign pos_x             = pos_x_q;
    assign pos_y             = pos_y_q;
    assign facing            = facing_q;
    assign busy              = (state_q != IDLE);
    assign blocked           = blocked_q;

endmodule
